// File: rtl/rx_operand_assembler.sv
// rx_operand_assembler: packs the Rx byte stream MSB-first into operands X then Y.
// Define CHECKSUM_EN to require a trailing XOR check byte before commit.
module rx_operand_assembler #(
  parameter int WIDTH       = 256,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_rx_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  input  logic             rx_ferr_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             err_o
);
  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam int GW     = $clog2(TIMEOUT_CYC + 1);
`ifdef CHECKSUM_EN
  localparam int SW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD_X, LOAD_Y, CHECK} state_t;
  logic [7:0] csum_q;
`else
  localparam int SW = 2 * WIDTH - 8;
  typedef enum logic [1:0] {IDLE, LOAD_X, LOAD_Y} state_t;
`endif
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [GW-1:0]    gap_q;
  logic [SW-1:0]    sh_q, sh_d;
  logic [2*WIDTH-1:0] frame;
  logic [WIDTH-1:0] x_q, y_q;
  logic             ready_q, busy_q, err_q, last;
  // Without a check byte the last Y byte is still on rx_data_i at commit time
  assign sh_d  = SW'({sh_q, rx_data_i});
`ifdef CHECKSUM_EN
  assign frame = sh_q;
`else
  assign frame = {sh_q, rx_data_i};
`endif
  assign last    = cnt_q == CW'(NBYTES - 1);
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (en_rx_i && rx_valid_i && !rx_ferr_i) begin
          state_q <= last ? LOAD_Y : LOAD_X;
          cnt_q   <= last ? '0 : cnt_q + 1'b1;
          gap_q   <= '0;
          sh_q    <= sh_d;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
`ifdef CHECKSUM_EN
          csum_q  <= rx_data_i;
`endif
        end
      end else if (!en_rx_i || (rx_valid_i && rx_ferr_i) ||
                   (!rx_valid_i && gap_q == GW'(TIMEOUT_CYC - 1))) begin
        // en_Rx drop aborts silently; framing error and timeout flag err
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
        err_q   <= en_rx_i;
      end else if (rx_valid_i) begin
        gap_q <= '0;
        sh_q  <= sh_d;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
`ifdef CHECKSUM_EN
        csum_q <= csum_q ^ rx_data_i;
`endif
        if (state_q == LOAD_X) state_q <= last ? LOAD_Y : LOAD_X;
`ifdef CHECKSUM_EN
        else if (state_q == LOAD_Y) state_q <= last ? CHECK : LOAD_Y;
        else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          err_q   <= rx_data_i != csum_q;
          if (rx_data_i == csum_q) begin
            x_q     <= frame[2*WIDTH-1:WIDTH];
            y_q     <= frame[WIDTH-1:0];
            ready_q <= 1'b1;
          end
        end
`else
        else if (last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          x_q     <= frame[2*WIDTH-1:WIDTH];
          y_q     <= frame[WIDTH-1:0];
          ready_q <= 1'b1;
        end
`endif
      end else gap_q <= gap_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_rx_operand_assembler.sv
// tb_rx_operand_assembler: directed spec scenarios plus randomized frames/aborts,
// checked against a queue-based frame model.
module tb_rx_operand_assembler;
  localparam int W  = 256;
  localparam int NB = W / 8;
  localparam int T  = 50;
`ifdef CHECKSUM_EN
  localparam int FL = 2 * NB + 1;
`else
  localparam int FL = 2 * NB;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en_rx = 1'b0, rx_valid = 1'b0, rx_ferr = 1'b0;
  logic [7:0] rx_data = '0;
  logic [W-1:0] x, y;
  logic ready, busy, err;
  int n_chk = 0, n_fail = 0, err_seen = 0, exp_err = 0, el = 0;
  logic [7:0] fq[$];
  logic [W-1:0] ex = '0, ey = '0;
  logic er = 1'b0;

  rx_operand_assembler #(.WIDTH(W), .TIMEOUT_CYC(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_rx_i(en_rx), .rx_data_i(rx_data),
    .rx_valid_i(rx_valid), .rx_ferr_i(rx_ferr), .x_o(x), .y_o(y),
    .ready_o(ready), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag);
    check({tag, "_busy"}, W'(busy), W'(fq.size() > 0));
    check({tag, "_ready"}, W'(ready), W'(er));
    check({tag, "_errcnt"}, W'(err_seen), W'(exp_err));
    check({tag, "_x"}, x, ex);
    check({tag, "_y"}, y, ey);
  endtask

  // Complete frame: place byte k at bits [W-1-8k -: 8] of its operand
  task automatic commit();
    logic [W-1:0] nx = '0, ny = '0;
`ifdef CHECKSUM_EN
    logic [7:0] cs = '0;
    for (int i = 0; i < 2 * NB; i++) cs ^= fq[i];
    if (fq[2*NB] != cs) begin
      exp_err++;
      fq.delete();
      return;
    end
`endif
    for (int i = 0; i < NB; i++) begin
      nx[W-1-8*i -: 8] = fq[i];
      ny[W-1-8*i -: 8] = fq[NB+i];
    end
    ex = nx;
    ey = ny;
    er = 1'b1;
    fq.delete();
  endtask

  // Frame-level model of what one clock edge with these inputs means
  task automatic m_edge(input bit v, input logic [7:0] b, input bit f);
    if (!en_rx) begin
      fq.delete();
      return;
    end
    if (v && f) begin
      if (fq.size() > 0) begin
        fq.delete();
        exp_err++;
      end
      return;
    end
    if (v) begin
      if (fq.size() == 0) er = 1'b0;
      fq.push_back(b);
      el = 0;
      if (fq.size() == FL) commit();
      return;
    end
    if (fq.size() > 0) begin
      el++;
      if (el >= T) begin
        fq.delete();
        exp_err++;
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] b, input bit f);
    rx_valid = v;
    rx_data  = b;
    rx_ferr  = f;
    @(negedge clk);
    #1;
    m_edge(v, b, f);
    rx_valid = 1'b0;
    if (v) chk_st("byte");
  endtask

  task automatic send(input logic [7:0] b, input bit f, input int s);
    repeat (s - 1) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, b, f);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
    chk_st("idle");
  endtask

  task automatic send_bytes(input int k);
    for (int i = 0; i < k; i++) send(8'($urandom), 1'b0, $urandom_range(1, 4));
  endtask

  task automatic send_frame(input bit ramp, input int s);
    logic [7:0] b;
`ifdef CHECKSUM_EN
    logic [7:0] cs = '0;
`endif
    for (int i = 0; i < 2 * NB; i++) begin
      b = ramp ? 8'(i) : 8'($urandom);
`ifdef CHECKSUM_EN
      cs ^= b;
`endif
      send(b, 1'b0, s > 0 ? s : $urandom_range(1, 4));
    end
`ifdef CHECKSUM_EN
    send(cs, 1'b0, s > 0 ? s : 2);
`endif
  endtask

  initial begin
    int a, k;
    #22;
    check("rst_x", x, '0);
    check("rst_y", y, '0);
    check("rst_ready", W'(ready), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_err", W'(err), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    en_rx = 1'b1;
    // Ramp frame, one byte every 10 clocks
    send_frame(1'b1, 10);
    check("ramp_x", x, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check("ramp_y", y, 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
    // Asynchronous reset in the middle of a frame, away from any clock edge
    for (int i = 0; i < 10; i++) send(8'(i + 7), 1'b0, 3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_x", x, '0);
    check("mid_rst_y", y, '0);
    check("mid_rst_ready", W'(ready), '0);
    check("mid_rst_busy", W'(busy), '0);
    check("mid_rst_err", W'(err), '0);
    fq.delete();
    ex = '0;
    ey = '0;
    er = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    send_frame(1'b1, 10);
    // Timeout after 40 bytes
    send_bytes(40);
    idle(T);
    // Gap of exactly T clocks is still accepted; T+1 times out
    for (int i = 0; i < FL; i++) send(8'($urandom), 1'b0, i == 5 ? T : 2);
    send_bytes(3);
    send(8'hA5, 1'b0, T + 1);
    idle(T);
    // Framing error on byte 5, then a clean frame
    send_bytes(5);
    send(8'h55, 1'b1, 2);
    idle(3);
    send_frame(1'b0, 0);
    // Framing error while idle is dropped
    send(8'h11, 1'b1, 2);
    idle(3);
    // en_Rx drop after byte 20, bytes with en_Rx low ignored
    send_bytes(21);
    en_rx = 1'b0;
    idle(3);
    send_bytes(4);
    idle(2);
    en_rx = 1'b1;
    // en_Rx fall in the same cycle as a strobe: abort wins
    send_bytes(10);
    en_rx = 1'b0;
    send(8'h77, 1'b0, 1);
    en_rx = 1'b1;
    idle(2);
    send_frame(1'b0, 0);
`ifdef CHECKSUM_EN
    send_frame(1'b1, 10);
    for (int i = 0; i < 2 * NB; i++) send(8'(i), 1'b0, 10);
    send(8'h01, 1'b0, 10);
    idle(2);
`endif
    for (int it = 0; it < 30; it++) begin
      a = $urandom_range(0, 6);
      k = $urandom_range(1, FL - 1);
      case (a)
        3: begin send_bytes(k); send(8'($urandom), 1'b1, 2); end
        4: begin send_bytes(k); en_rx = 1'b0; idle($urandom_range(1, 3)); en_rx = 1'b1; end
        5: begin send_bytes(k); idle(T + $urandom_range(0, 3)); end
        6: begin send(8'($urandom), 1'b1, 2); send_frame(1'b0, 0); end
        default: send_frame(1'b0, 0);
      endcase
    end
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
